// File: rtl/pc_stack_param.sv
// Program-counter stack with serial, word-at-a-time address fetch.
// The active slot is incremented one word per fetch sub-cycle with a
// rippled carry, then call/return/jump is applied on the execute cycle.
module pc_stack_param #(
  parameter  int WORD_W = 4,
  parameter  int NWORDS = 3,
  parameter  int DEPTH  = 4,
  localparam int AW     = WORD_W * NWORDS,
  localparam int SW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        cycle,
  input  logic [1:0]        control,
  input  logic [AW-1:0]     target,
  input  logic              clear_flags,
  output logic [AW-1:0]     pc,
  output logic              pc_enable,
  output logic [WORD_W-1:0] pc_word,
  output logic [SW-1:0]     sp,
  output logic [SW-1:0]     level,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_JUMP = 2'd3
  } op_e;

  localparam logic [2:0]    EXEC_CYCLE = 3'(NWORDS);
  localparam logic [SW-1:0] LEVEL_MAX  = SW'(DEPTH - 1);

  logic [AW-1:0]     slot_q [DEPTH];
  logic [SW-1:0]     sp_q;
  logic [SW-1:0]     level_q;
  logic              carry_q;
  logic              overflow_q;
  logic              underflow_q;

  logic [WORD_W-1:0] word_sel;
  logic              word_active;
  logic              inc_bit;
  logic [WORD_W:0]   word_sum;
  logic [AW-1:0]     pc_inc;
  logic [SW-1:0]     sp_up;
  logic [SW-1:0]     sp_down;
  op_e               op;

  assign op      = op_e'(control);
  assign pc      = slot_q[sp_q];
  assign sp_up   = sp_q + 1'b1;
  assign sp_down = sp_q - 1'b1;

  // Pick the address word named by the sub-cycle; other cycles drive zero.
  always_comb begin
    word_sel    = '0;
    word_active = 1'b0;
    for (int k = 0; k < NWORDS; k++) begin
      if (cycle == 3'(k)) begin
        word_sel    = pc[k*WORD_W +: WORD_W];
        word_active = 1'b1;
      end
    end
  end

  assign pc_word   = word_sel;
  assign pc_enable = word_active;

  // Word 0 gets the +1, higher words absorb the carry from the previous word.
  assign inc_bit  = (cycle == 3'd0) ? 1'b1 : carry_q;
  assign word_sum = {1'b0, word_sel} + {{WORD_W{1'b0}}, inc_bit};

  // Splice the incremented word back into the full address.
  always_comb begin
    pc_inc = pc;
    for (int k = 0; k < NWORDS; k++) begin
      if (cycle == 3'(k)) begin
        pc_inc[k*WORD_W +: WORD_W] = word_sum[WORD_W-1:0];
      end
    end
  end

  // Stack, pointer, depth and flag state; a set event overrides a clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      sp_q        <= '0;
      level_q     <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (clear_flags) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (word_active) begin
        // Carry out of the top word lands in carry_q but is never consumed,
        // since the next fetch restarts at word 0 with a fresh +1.
        slot_q[sp_q] <= pc_inc;
        carry_q      <= word_sum[WORD_W];
      end else if (cycle == EXEC_CYCLE) begin
        case (op)
          OP_JUMP: slot_q[sp_q] <= target;
          OP_PUSH: begin
            slot_q[sp_up] <= target;
            sp_q          <= sp_up;
            if (level_q != LEVEL_MAX) level_q <= level_q + 1'b1;
            else                      overflow_q <= 1'b1;
          end
          OP_POP: begin
            sp_q <= sp_down;
            if (level_q != '0) level_q <= level_q - 1'b1;
            else               underflow_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign sp        = sp_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack_param.sv
// Bench for pc_stack_param: directed vector table, hand sequences for
// reset/overflow/underflow/flag corners, and randomized instructions
// compared against an instruction-level stack model.
module tb_pc_stack_param;

  localparam int WW = 4;
  localparam int NW = 3;
  localparam int DP = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  cycle;
  logic [1:0]  control;
  logic [11:0] target;
  logic        clear_flags;
  logic [11:0] pc;
  logic        pc_enable;
  logic [3:0]  pc_word;
  logic [1:0]  sp;
  logic [1:0]  level;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  pc_stack_param #(.WORD_W(WW), .NWORDS(NW), .DEPTH(DP)) dut (
    .clock(clock), .reset(reset), .cycle(cycle), .control(control),
    .target(target), .clear_flags(clear_flags), .pc(pc),
    .pc_enable(pc_enable), .pc_word(pc_word), .sp(sp), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  c;
    logic [1:0]  o;
    logic [11:0] t;
    logic        cl;
    logic [3:0]  w;
    logic        e;
    logic [11:0] p;
    logic [1:0]  s;
    logic [1:0]  l;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] c, logic [1:0] o, logic [11:0] t,
                              logic cl, logic [3:0] w, logic e, logic [11:0] p,
                              logic [1:0] s, logic [1:0] l, logic ov, logic un);
    vec_t v;
    v.c = c; v.o = o; v.t = t; v.cl = cl; v.w = w; v.e = e;
    v.p = p; v.s = s; v.l = l; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] c, input logic [1:0] o,
                      input logic [11:0] t, input logic cl);
    cycle = c; control = o; target = t; clear_flags = cl;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic chk_state(input string nm, input logic [11:0] p, input logic [1:0] s,
                           input logic [1:0] l, input logic ov, input logic un);
    chk({nm, ".pc"}, 32'(pc), 32'(p));
    chk({nm, ".sp"}, 32'(sp), 32'(s));
    chk({nm, ".level"}, 32'(level), 32'(l));
    chk({nm, ".overflow"}, 32'(overflow), 32'(ov));
    chk({nm, ".underflow"}, 32'(underflow), 32'(un));
  endtask

  // Instruction-level reference model: addresses are plain integers,
  // the whole +1 is applied once the last fetch word has gone by.
  int m_slot[DP];
  int m_sp, m_lvl;
  bit m_ov, m_un;

  task automatic m_reset();
    for (int i = 0; i < DP; i++) m_slot[i] = 0;
    m_sp = 0; m_lvl = 0; m_ov = 0; m_un = 0;
  endtask

  task automatic m_edge(input int c, input int o, input int t, input bit cl);
    if (cl) begin m_ov = 0; m_un = 0; end
    if (c == NW - 1) begin
      m_slot[m_sp] = (m_slot[m_sp] + 1) % (1 << (WW * NW));
    end else if (c == NW) begin
      case (o)
        1: begin
          m_sp = (m_sp + 1) % DP;
          m_slot[m_sp] = t;
          if (m_lvl < DP - 1) m_lvl++; else m_ov = 1;
        end
        2: begin
          m_sp = (m_sp + DP - 1) % DP;
          if (m_lvl > 0) m_lvl--; else m_un = 1;
        end
        3: m_slot[m_sp] = t;
        default: ;
      endcase
    end
  endtask

  initial begin
    reset = 1'b0; cycle = 3'd0; control = 2'd0; target = 12'h000; clear_flags = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk_state("reset", 12'h000, 2'd0, 2'd0, 1'b0, 1'b0);
    chk("reset.word", 32'(pc_word), 32'h0);
    chk("reset.enable", 32'(pc_enable), 32'h1);

    // c, ctl, target, clr | word, en | pc, sp, level, ov, un (after the edge)
    vecs.push_back(mk(3'd0, 2'd0, 12'h000, 1'b0, 4'h0, 1'b1, 12'h001, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd0, 12'h000, 1'b0, 4'h0, 1'b1, 12'h001, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd0, 12'h000, 1'b0, 4'h0, 1'b1, 12'h001, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd0, 12'h000, 1'b0, 4'h0, 1'b0, 12'h001, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd3, 12'h0FF, 1'b0, 4'h0, 1'b0, 12'h0FF, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd0, 2'd0, 12'h000, 1'b0, 4'hF, 1'b1, 12'h0F0, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd0, 12'h000, 1'b0, 4'hF, 1'b1, 12'h000, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd0, 12'h000, 1'b0, 4'h0, 1'b1, 12'h100, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd0, 12'h000, 1'b0, 4'h0, 1'b0, 12'h100, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd3, 12'hFFF, 1'b0, 4'h0, 1'b0, 12'hFFF, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd0, 2'd0, 12'h000, 1'b0, 4'hF, 1'b1, 12'hFF0, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd0, 12'h000, 1'b0, 4'hF, 1'b1, 12'hF00, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd0, 12'h000, 1'b0, 4'hF, 1'b1, 12'h000, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd0, 12'h000, 1'b0, 4'h0, 1'b0, 12'h000, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd3, 12'h123, 1'b0, 4'h0, 1'b0, 12'h123, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd0, 2'd1, 12'hAAA, 1'b0, 4'h3, 1'b1, 12'h124, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd2, 12'hAAA, 1'b0, 4'h2, 1'b1, 12'h124, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd3, 12'hAAA, 1'b0, 4'h1, 1'b1, 12'h124, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd1, 12'h456, 1'b0, 4'h0, 1'b0, 12'h456, 2'd1, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(3'd0, 2'd0, 12'h000, 1'b0, 4'h6, 1'b1, 12'h457, 2'd1, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd0, 12'h000, 1'b0, 4'h5, 1'b1, 12'h457, 2'd1, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd0, 12'h000, 1'b0, 4'h4, 1'b1, 12'h457, 2'd1, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd2, 12'h000, 1'b0, 4'h0, 1'b0, 12'h124, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd4, 2'd1, 12'h777, 1'b0, 4'h0, 1'b0, 12'h124, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd5, 2'd2, 12'h777, 1'b0, 4'h0, 1'b0, 12'h124, 2'd0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd7, 2'd3, 12'h777, 1'b1, 4'h0, 1'b0, 12'h124, 2'd0, 2'd0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      cycle = vecs[i].c; control = vecs[i].o; target = vecs[i].t; clear_flags = vecs[i].cl;
      #1;
      chk($sformatf("vec%0d.word", i), 32'(pc_word), 32'(vecs[i].w));
      chk($sformatf("vec%0d.enable", i), 32'(pc_enable), 32'(vecs[i].e));
      @(posedge clock); #1;
      chk_state($sformatf("vec%0d", i), vecs[i].p, vecs[i].s, vecs[i].l, vecs[i].ov, vecs[i].un);
    end

    // Four pushes from reset: the fourth wraps sp and overflows.
    do_reset();
    step(3'd3, 2'd1, 12'h111, 1'b0); chk_state("push1", 12'h111, 2'd1, 2'd1, 1'b0, 1'b0);
    step(3'd3, 2'd1, 12'h222, 1'b0); chk_state("push2", 12'h222, 2'd2, 2'd2, 1'b0, 1'b0);
    step(3'd3, 2'd1, 12'h333, 1'b0); chk_state("push3", 12'h333, 2'd3, 2'd3, 1'b0, 1'b0);
    step(3'd3, 2'd1, 12'h444, 1'b0); chk_state("push4", 12'h444, 2'd0, 2'd3, 1'b1, 1'b0);
    // Clear and overflowing push together: set wins. Then clear alone.
    step(3'd3, 2'd1, 12'h555, 1'b1); chk_state("clr_vs_set", 12'h555, 2'd1, 2'd3, 1'b1, 1'b0);
    step(3'd3, 2'd0, 12'h000, 1'b1); chk_state("clr_only", 12'h555, 2'd1, 2'd3, 1'b0, 1'b0);
    // Pops unwind: slot left behind by a pop keeps its contents.
    step(3'd3, 2'd2, 12'h000, 1'b0); chk_state("pop_a", 12'h444, 2'd0, 2'd2, 1'b0, 1'b0);

    // Pop on an empty stack from reset.
    do_reset();
    step(3'd3, 2'd2, 12'h000, 1'b0); chk_state("pop_empty", 12'h000, 2'd3, 2'd0, 1'b0, 1'b1);

    // Reset mid-fetch discards the partial increment; reset ignores control.
    step(3'd3, 2'd3, 12'h0FF, 1'b0);
    step(3'd0, 2'd0, 12'h000, 1'b0);
    step(3'd1, 2'd0, 12'h000, 1'b0); chk_state("midfetch_pre", 12'h000, 2'd3, 2'd0, 1'b0, 1'b1);
    cycle = 3'd2; do_reset();        chk_state("midfetch_rst", 12'h000, 2'd0, 2'd0, 1'b0, 1'b0);
    cycle = 3'd3; control = 2'd3; target = 12'hABC; clear_flags = 1'b1;
    do_reset();                      chk_state("rst_ignores_jump", 12'h000, 2'd0, 2'd0, 1'b0, 1'b0);
    step(3'd0, 2'd0, 12'h000, 1'b0);
    step(3'd1, 2'd0, 12'h000, 1'b0);
    step(3'd2, 2'd0, 12'h000, 1'b0); chk_state("fetch_after_rst", 12'h001, 2'd0, 2'd0, 1'b0, 1'b0);

    // Randomized instructions against the model.
    do_reset();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        cycle = 3'($urandom); control = 2'($urandom); target = 12'($urandom);
        clear_flags = 1'($urandom);
        do_reset();
        m_reset();
      end else if (r < 3) begin
        cycle = 3'($urandom_range(4, 7)); control = 2'($urandom);
        target = 12'($urandom); clear_flags = ($urandom_range(0, 5) == 0);
        #1;
        chk("rnd.idle_word", 32'(pc_word), 32'h0);
        chk("rnd.idle_enable", 32'(pc_enable), 32'h0);
        @(posedge clock); #1;
        m_edge(int'(cycle), int'(control), int'(target), clear_flags);
      end else begin
        for (int k = 0; k < NW; k++) begin
          cycle = 3'(k); control = 2'($urandom); target = 12'($urandom);
          clear_flags = ($urandom_range(0, 7) == 0);
          #1;
          chk("rnd.word", 32'(pc_word), 32'((m_slot[m_sp] >> (WW * k)) & ((1 << WW) - 1)));
          chk("rnd.enable", 32'(pc_enable), 32'h1);
          @(posedge clock); #1;
          m_edge(k, int'(control), int'(target), clear_flags);
        end
        cycle = 3'(NW); control = 2'($urandom); target = 12'($urandom);
        clear_flags = ($urandom_range(0, 7) == 0);
        @(posedge clock); #1;
        m_edge(NW, int'(control), int'(target), clear_flags);
      end
      chk_state("rnd", 12'(m_slot[m_sp]), 2'(m_sp), 2'(m_lvl), m_ov, m_un);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
